// File: rtl/shift_pkg.sv
// Shared constants and types for the shift arbiter slice.
// Shift-type encodings, requester count, data width, buffer states.
package shift_pkg;

   localparam int NREQ = 2;
   localparam int XLEN = 32;
   localparam int SHW  = 5;

   localparam logic [1:0] SH_SRL = 2'b00;
   localparam logic [1:0] SH_SLL = 2'b01;
   localparam logic [1:0] SH_SRA = 2'b10;
   localparam logic [1:0] SH_RSV = 2'b11;

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a last-grant pointer.
// Ports: clk, rst (async active-low), elig (eligible), grant (one-hot).
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] elig,
   output logic [1:0] grant
);

   logic last_grant;

   // On contention the requester not granted last wins.
   assign grant[0] = elig[0] & (~elig[1] | last_grant);
   assign grant[1] = elig[1] & (~elig[0] | ~last_grant);

   // Reset to 1 so requester 0 wins the first contention.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_grant <= 1'b1;
      else if (|grant)
         last_grant <= grant[1];
   end

endmodule

// File: rtl/shift_unit.sv
// Combinational 32-bit barrel shifter: SRL, SLL, SRA.
// Ports: a (operand), shamt (0..31), sh_type, y (result).
module shift_unit
   import shift_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [SHW-1:0]  shamt,
   input  logic [1:0]      sh_type,
   output logic [XLEN-1:0] y
);

   always_comb begin
      y = a;
      unique case (sh_type)
         SH_SRL:  y = a >> shamt;
         SH_SLL:  y = a << shamt;
         SH_SRA:  y = $signed(a) >>> shamt;
         default: y = a;
      endcase
   end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrel shifter between two requesters, round-robin,
// with a one-entry response buffer per requester.
// Ports: clk, rst (async active-low), req_* (request handshake and
// operands per requester), rsp_* (buffered result handshake, data, tag).
module shift_arbiter
   import shift_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*XLEN-1:0]  req_a,
   input  logic [NREQ*SHW-1:0]   req_shamt,
   input  logic [NREQ*2-1:0]     req_type,
   input  logic [NREQ*TAG_W-1:0] req_tag,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [NREQ*XLEN-1:0]  rsp_data,
   output logic [NREQ*TAG_W-1:0] rsp_tag
);

   logic [NREQ-1:0]  elig;
   logic [NREQ-1:0]  grant;
   logic             sel;
   logic [XLEN-1:0]  op_a;
   logic [SHW-1:0]   op_shamt;
   logic [1:0]       op_type;
   logic [TAG_W-1:0] op_tag;
   logic [XLEN-1:0]  sh_y;
   logic [XLEN-1:0]  result;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .elig  (elig),
      .grant (grant)
   );

   // Ready is the grant itself; elig is already gated by reset.
   assign req_ready = grant;

   // Operand mux: grant is one-hot, so grant[1] selects requester 1.
   assign sel      = grant[1];
   assign op_a     = sel ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
   assign op_shamt = sel ? req_shamt[2*SHW-1:SHW] : req_shamt[SHW-1:0];
   assign op_type  = sel ? req_type[3:2] : req_type[1:0];
   assign op_tag   = sel ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];

   shift_unit u_shift (
      .a       (op_a),
      .shamt   (op_shamt),
      .sh_type (op_type),
      .y       (sh_y)
   );

   // Reserved type passes the operand through untouched.
   assign result = (op_type == SH_RSV) ? op_a : sh_y;

   for (genvar g = 0; g < NREQ; g++) begin : g_buf
      buf_state_e       state_q;
      buf_state_e       state_d;
      logic [XLEN-1:0]  data_q;
      logic [TAG_W-1:0] tag_q;
      logic             acc;
      logic             drain;

      assign acc   = grant[g];
      assign drain = (state_q == BUF_FULL) & rsp_ready[g];

      // A full buffer may accept in the same cycle it drains.
      assign elig[g] = rst & req_valid[g]
                     & ((state_q == BUF_EMPTY) | drain);

      always_comb begin
         state_d = state_q;
         unique case (state_q)
            BUF_EMPTY: if (acc) state_d = BUF_FULL;
            BUF_FULL: begin
               if (acc)
                  state_d = BUF_FULL;
               else if (drain)
                  state_d = BUF_EMPTY;
            end
         endcase
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst)
            state_q <= BUF_EMPTY;
         else
            state_q <= state_d;
      end

      // Contents hold across drain; only a new accept overwrites.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            data_q <= '0;
            tag_q  <= '0;
         end else if (acc) begin
            data_q <= result;
            tag_q  <= op_tag;
         end
      end

      assign rsp_valid[g]                   = (state_q == BUF_FULL);
      assign rsp_data[g*XLEN +: XLEN]       = data_q;
      assign rsp_tag[g*TAG_W +: TAG_W]      = tag_q;
   end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed vector table
// plus hand-written contention, backpressure, streaming, reset cases.
module tb_shift_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_a;
   logic [9:0]  req_shamt;
   logic [3:0]  req_type;
   logic [7:0]  req_tag;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [63:0] rsp_data;
   logic [7:0]  rsp_tag;

   int errors;
   int checks;

   shift_arbiter #(.TAG_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_shamt (req_shamt),
      .req_type  (req_type),
      .req_tag   (req_tag),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_tag   (rsp_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          port;
      logic [31:0] a;
      logic [4:0]  shamt;
      logic [1:0]  typ;
      logic [3:0]  tag;
      logic [31:0] exp;
   } vec_t;

   vec_t tv[12];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_req(input int p, input logic [31:0] a,
                          input logic [4:0] sh, input logic [1:0] ty,
                          input logic [3:0] tg);
      req_a[p*32 +: 32]   = a;
      req_shamt[p*5 +: 5] = sh;
      req_type[p*2 +: 2]  = ty;
      req_tag[p*4 +: 4]   = tg;
   endtask

   initial begin
      logic [1:0] oh;
      logic [3:0] t0;
      logic [3:0] t1;
      int         g;

      errors    = 0;
      checks    = 0;
      rst       = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      req_a     = '0;
      req_shamt = '0;
      req_type  = '0;
      req_tag   = '0;

      tv[0]  = '{0, 32'h0000_00F0, 5'd4,  2'b00, 4'd1, 32'h0000_000F};
      tv[1]  = '{1, 32'h8000_0000, 5'd31, 2'b10, 4'd2, 32'hFFFF_FFFF};
      tv[2]  = '{0, 32'h0000_0001, 5'd31, 2'b01, 4'd3, 32'h8000_0000};
      tv[3]  = '{1, 32'h1234_5678, 5'd7,  2'b11, 4'd4, 32'h1234_5678};
      tv[4]  = '{0, 32'hDEAD_BEEF, 5'd0,  2'b00, 4'd5, 32'hDEAD_BEEF};
      tv[5]  = '{1, 32'hDEAD_BEEF, 5'd0,  2'b01, 4'd6, 32'hDEAD_BEEF};
      tv[6]  = '{0, 32'hDEAD_BEEF, 5'd0,  2'b10, 4'd7, 32'hDEAD_BEEF};
      tv[7]  = '{1, 32'h8000_0000, 5'd31, 2'b00, 4'd8, 32'h0000_0001};
      tv[8]  = '{0, 32'h7FFF_FFFF, 5'd4,  2'b10, 4'd9, 32'h07FF_FFFF};
      tv[9]  = '{1, 32'hF000_0000, 5'd4,  2'b10, 4'hA, 32'hFF00_0000};
      tv[10] = '{0, 32'h1234_5678, 5'd8,  2'b01, 4'hB, 32'h3456_7800};
      tv[11] = '{1, 32'h0000_0001, 5'd1,  2'b01, 4'hC, 32'h0000_0002};

      // Reset held with inputs toggling.
      repeat (2) @(negedge clk);
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      set_req(0, 32'hFFFF_FFFF, 5'd3, 2'b01, 4'hF);
      @(posedge clk);
      #1;
      chk("rst_ready", {62'd0, req_ready}, 64'd0);
      chk("rst_valid", {62'd0, rsp_valid}, 64'd0);
      chk("rst_data", rsp_data, 64'd0);
      chk("rst_tag", {56'd0, rsp_tag}, 64'd0);

      // First request right after release.
      @(negedge clk);
      rst       = 1'b1;
      rsp_ready = 2'b00;
      req_valid = 2'b01;
      set_req(0, 32'h0000_00F0, 5'd4, 2'b00, 4'd0);
      #1;
      chk("first_ready", {62'd0, req_ready}, 64'd1);
      @(negedge clk);
      req_valid = 2'b00;
      chk("first_valid", {62'd0, rsp_valid}, 64'd1);
      chk("first_data", {32'd0, rsp_data[31:0]}, 64'h0F);
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;
      chk("first_drain", {62'd0, rsp_valid}, 64'd0);

      // Vector table, one isolated request each.
      for (int i = 0; i < 12; i++) begin
         oh = 2'b01 << tv[i].port;
         set_req(tv[i].port, tv[i].a, tv[i].shamt, tv[i].typ, tv[i].tag);
         req_valid = oh;
         #1;
         chk($sformatf("v%0d_ready", i), {62'd0, req_ready}, {62'd0, oh});
         @(negedge clk);
         req_valid = 2'b00;
         chk($sformatf("v%0d_valid", i), {62'd0, rsp_valid}, {62'd0, oh});
         chk($sformatf("v%0d_data", i),
             {32'd0, rsp_data[tv[i].port*32 +: 32]}, {32'd0, tv[i].exp});
         chk($sformatf("v%0d_tag", i),
             {60'd0, rsp_tag[tv[i].port*4 +: 4]}, {60'd0, tv[i].tag});
         rsp_ready = oh;
         @(negedge clk);
         rsp_ready = 2'b00;
         chk($sformatf("v%0d_drain", i), {62'd0, rsp_valid}, 64'd0);
      end

      // Contention: grants alternate starting with port 0.
      t0 = 4'd0;
      t1 = 4'd8;
      g  = 0;
      rsp_ready = 2'b11;
      set_req(0, {28'hA000_000, t0}, 5'd0, 2'b00, t0);
      set_req(1, {28'hB000_000, t1}, 5'd0, 2'b00, t1);
      req_valid = 2'b11;
      for (int k = 0; k < 6; k++) begin
         oh = 2'b01 << g;
         #1;
         chk($sformatf("ct%0d_grant", k), {62'd0, req_ready}, {62'd0, oh});
         @(negedge clk);
         chk($sformatf("ct%0d_valid", k), {62'd0, rsp_valid}, {62'd0, oh});
         if (g == 0) begin
            chk($sformatf("ct%0d_tag", k), {60'd0, rsp_tag[3:0]},
                {60'd0, t0});
            chk($sformatf("ct%0d_data", k), {32'd0, rsp_data[31:0]},
                {32'd0, 28'hA000_000, t0});
            t0 = t0 + 4'd1;
            set_req(0, {28'hA000_000, t0}, 5'd0, 2'b00, t0);
         end else begin
            chk($sformatf("ct%0d_tag", k), {60'd0, rsp_tag[7:4]},
                {60'd0, t1});
            chk($sformatf("ct%0d_data", k), {32'd0, rsp_data[63:32]},
                {32'd0, 28'hB000_000, t1});
            t1 = t1 + 4'd1;
            set_req(1, {28'hB000_000, t1}, 5'd0, 2'b00, t1);
         end
         g = 1 - g;
      end
      req_valid = 2'b00;
      @(negedge clk);
      chk("ct_drain", {62'd0, rsp_valid}, 64'd0);
      rsp_ready = 2'b00;

      // Backpressure on port 0, port 1 runs alongside.
      set_req(0, 32'h10, 5'd1, 2'b01, 4'd5);
      req_valid = 2'b01;
      #1;
      chk("bp_acc1", {62'd0, req_ready}, 64'd1);
      @(negedge clk);
      set_req(0, 32'h10, 5'd2, 2'b01, 4'd6);
      set_req(1, 32'h80, 5'd3, 2'b00, 4'd9);
      req_valid = 2'b11;
      rsp_ready = 2'b10;
      #1;
      chk("bp_block", {62'd0, req_ready}, 64'd2);
      @(negedge clk);
      req_valid = 2'b01;
      chk("bp_valid11", {62'd0, rsp_valid}, 64'd3);
      chk("bp_hold0", {32'd0, rsp_data[31:0]}, 64'h20);
      chk("bp_p1data", {32'd0, rsp_data[63:32]}, 64'h10);
      chk("bp_p1tag", {60'd0, rsp_tag[7:4]}, 64'd9);
      #1;
      chk("bp_still", {62'd0, req_ready}, 64'd0);
      @(negedge clk);
      chk("bp_valid01", {62'd0, rsp_valid}, 64'd1);
      chk("bp_hold0b", {32'd0, rsp_data[31:0]}, 64'h20);
      chk("bp_tag0", {60'd0, rsp_tag[3:0]}, 64'd5);
      rsp_ready = 2'b01;
      #1;
      chk("bp_release", {62'd0, req_ready}, 64'd1);
      @(negedge clk);
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      chk("bp_replace_v", {62'd0, rsp_valid}, 64'd1);
      chk("bp_replace_d", {32'd0, rsp_data[31:0]}, 64'h40);
      chk("bp_replace_t", {60'd0, rsp_tag[3:0]}, 64'd6);
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;
      chk("bp_drain", {62'd0, rsp_valid}, 64'd0);

      // Streaming: 8 back-to-back requests on port 0.
      rsp_ready = 2'b01;
      req_valid = 2'b01;
      for (int i = 0; i < 8; i++) begin
         set_req(0, 32'(i + 3), 5'd1, 2'b01, 4'(i));
         #1;
         chk($sformatf("st%0d_ready", i), {62'd0, req_ready}, 64'd1);
         @(negedge clk);
         chk($sformatf("st%0d_valid", i), {62'd0, rsp_valid}, 64'd1);
         chk($sformatf("st%0d_tag", i), {60'd0, rsp_tag[3:0]},
             64'(i));
         chk($sformatf("st%0d_data", i), {32'd0, rsp_data[31:0]},
             64'((i + 3) * 2));
      end
      req_valid = 2'b00;
      @(negedge clk);
      chk("st_drain", {62'd0, rsp_valid}, 64'd0);
      rsp_ready = 2'b00;

      // Reset while a result sits in buffer 1.
      set_req(1, 32'hCAFE_0000, 5'd16, 2'b00, 4'd3);
      req_valid = 2'b10;
      @(negedge clk);
      chk("mr_valid", {62'd0, rsp_valid}, 64'd2);
      chk("mr_data", {32'd0, rsp_data[63:32]}, 64'hCAFE);
      #2;
      rst = 1'b0;
      #1;
      chk("mr_async_v", {62'd0, rsp_valid}, 64'd0);
      chk("mr_async_d", rsp_data, 64'd0);
      chk("mr_ready", {62'd0, req_ready}, 64'd0);
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      @(negedge clk);
      chk("mr_post_v", {62'd0, rsp_valid}, 64'd0);
      @(negedge clk);
      chk("mr_post_v2", {62'd0, rsp_valid}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares the single 32-bit barrel-shift unit between two requesters: the execute-stage ALU path (port 0) and the multi-cycle/auxiliary unit (port 1). Arbitrates round-robin with valid/ready handshakes, drives the shift unit with the granted operands, and registers each result into a per-requester one-entry response buffer. It sits beside the ALU in the execute stage and is the only instantiator of the shift unit.

## Interface
Parameters:
- TAG_W, 4, width of the opaque request tag echoed with each result

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; one-hot or zero
- req_a  in  64  operands, requester i in bits [32i+31:32i]
- req_shamt  in  10  shift amounts, 5 bits per requester
- req_type  in  4  shift type, 2 bits per requester: 00 SRL, 01 SLL, 10 SRA, 11 reserved
- req_tag  in  2*TAG_W  request tags
- rsp_valid  out  2  result buffer i holds a result
- rsp_ready  in  2  requester i consumes its result
- rsp_data  out  64  results, requester i in bits [32i+31:32i]
- rsp_tag  out  2*TAG_W  tag echoed with each result

## Operation
- Request handshake: transfer when req_valid[i] & req_ready[i]. Requester holds a, shamt, type, tag stable while valid and not ready; deasserting valid before accept is illegal.
- Eligibility: requester i eligible when req_valid[i] and buffer i is EMPTY or draining this cycle (rsp_valid[i] & rsp_ready[i]).
- Arbitration: at most one grant per cycle. Both eligible -> grant the requester not granted last. One eligible -> grant it. Pointer (last_grant) updates only on a grant.
- Datapath: granted operands drive the shift unit combinationally; result and tag captured into buffer i on the accepting edge.
- Arithmetic: SRL logical right, SLL left, SRA arithmetic right (sign fill from a[31]); shamt is 5 bits, 0..31, no wrap. Type 11: result = a unchanged (shamt ignored), never X.
- Per-buffer FSM: EMPTY -> FULL on accept; FULL -> EMPTY on drain with no accept; FULL -> FULL on simultaneous drain + accept (new data replaces old); EMPTY stays EMPTY on drain attempt (rsp_ready ignored when not valid).
- rsp_data/rsp_tag hold their value while FULL and not drained; undefined content not allowed, retain last value when EMPTY.
- Fairness: a continuously valid requester with a free buffer is granted within 2 cycles.

## Timing
- Reset (rst low, asynchronous): rsp_valid = 00, rsp_data = 0, rsp_tag = 0, last_grant = 1 (requester 0 wins first contention), req_ready = 00 while in reset.
- req_ready is combinational from req_valid, buffer state, rsp_ready and last_grant; no combinational path from req_a/req_shamt/req_type to any output.
- Latency: accept at edge N -> rsp_valid[i] high and rsp_data valid after edge N, visible in cycle N+1.
- Throughput: one shift per cycle total; a lone requester with rsp_ready held high sustains 1 result/cycle.
- Reset asserted mid-operation: in-flight accepts and buffered results are discarded; no response emitted after release.
- First grant possible in the first cycle after rst deasserts.

## Structure
- Shared package shift_pkg: shift-type constants SH_SRL=2'b00, SH_SLL=2'b01, SH_SRA=2'b10, SH_RSV=2'b11; NREQ=2; XLEN=32.
- Sub-module rr_arb2: two-requester round-robin arbiter (eligible vector in, one-hot grant out, pointer register with async active-low reset).
- Top instantiates rr_arb2, the existing shift unit, a 2:1 operand mux, and two buffer registers; type 11 handled by a bypass mux in front of the buffers.

## Test plan
- Reset: hold rst low, toggle inputs -> rsp_valid=00, rsp_data=0, req_ready=00; release, req_valid=01, a=0x0000_00F0, shamt=4, SRL -> accept cycle 0, rsp_data[31:0]=0x0000_000F, rsp_valid=01 next cycle.
- Arithmetic: port 1 SRA a=0x8000_0000 shamt=31 -> 0xFFFF_FFFF; SLL a=0x0000_0001 shamt=31 -> 0x8000_0000; type 11 a=0x1234_5678 shamt=7 -> 0x1234_5678; shamt=0 any type -> a.
- Contention: both valid continuously, rsp_ready=11 -> grants alternate 0,1,0,1; tags echoed on correct port; each port sees one result every 2 cycles.
- Backpressure: port 0 rsp_ready=0, two requests queued -> first accepted, second req_ready[0]=0 until rsp_ready[0] rises; on that cycle drain + accept, rsp_valid[0] stays 1 with new data; port 1 unaffected meanwhile.
- Streaming: port 0 only, rsp_ready held 1, 8 back-to-back requests -> 8 results on 8 consecutive cycles, in order, tags 0..7.
- Reset mid-flight: accept request, assert rst before drain -> rsp_valid=00 immediately (asynchronous) and no stale result after release.
